// File: rtl/music_pkg.sv
// Shared definitions for the tone path: score entry layout, note codes and
// sequencer states used by note_sequencer and freq_controller.
package music_pkg;

   localparam int SEL_HI  = 11;
   localparam int SEL_LO  = 10;
   localparam int NOTE_HI = 9;
   localparam int NOTE_LO = 6;
   localparam int DUR_HI  = 5;
   localparam int DUR_LO  = 2;

   localparam logic [3:0] NOTE_REST = 4'd0;
   localparam logic [3:0] NOTE_END  = 4'd15;

   // Pitch codes within one octave; the octave itself comes from sel.
   typedef enum logic [3:0] {
      N_C    = 4'd1,
      N_CS   = 4'd2,
      N_D    = 4'd3,
      N_DS   = 4'd4,
      N_E    = 4'd5,
      N_F    = 4'd6,
      N_FS   = 4'd7,
      N_G    = 4'd8,
      N_GS   = 4'd9,
      N_A    = 4'd10,
      N_AS   = 4'd11,
      N_B    = 4'd12,
      N_C_HI = 4'd13,
      N_D_HI = 4'd14
   } note_code_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_PAUSE,
      S_DONE
   } seq_state_t;

   // A duration field of 0 encodes the longest note, 16 beats.
   function automatic logic [4:0] dur_beats(input logic [3:0] dur);
      return (dur == 4'd0) ? 5'd16 : {1'b0, dur};
   endfunction

endpackage

// File: rtl/beat_timer.sv
// Loadable down-counter that times the sounding and gap phases of a note.
// hit flags the last cycle of a loaded interval (count == 1).
module beat_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         hit
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign hit = (count_q == W'(1));

endmodule

// File: rtl/note_sequencer.sv
// Score-playback controller: fetches entries from a synchronous score ROM and
// drives octave/note/gate into freq_controller with play, pause, stop and loop.
module note_sequencer
   import music_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int TICK_DIV = 12_500_000,
   parameter int GAP_CYC  = 500_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              play,
   input  logic              pause,
   input  logic              stop,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [11:0]       rom_data,
   output logic [1:0]        sel,
   output logic [3:0]        note,
   output logic              note_on,
   output logic              busy,
   output logic              done
);

   localparam int TW = $clog2(16 * TICK_DIV);

   seq_state_t        state_q, state_d;
   seq_state_t        saved_q, saved_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [1:0]        sel_q, sel_d;
   logic [3:0]        note_q, note_d;
   logic              note_on_q, note_on_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              t_load, t_en, t_hit;
   logic [TW-1:0]     t_load_val;
   logic [TW-1:0]     play_len;

   logic [1:0]        rom_sel;
   logic [3:0]        rom_note;
   logic [3:0]        rom_dur;
   logic              unused_rsvd;

   assign rom_sel     = rom_data[SEL_HI:SEL_LO];
   assign rom_note    = rom_data[NOTE_HI:NOTE_LO];
   assign rom_dur     = rom_data[DUR_HI:DUR_LO];
   assign unused_rsvd = ^rom_data[1:0];

   // Sounding part of a note; the gap is carved out of the full duration.
   assign play_len = TW'(dur_beats(rom_dur)) * TW'(TICK_DIV) - TW'(GAP_CYC);

   assign t_en = (state_q == S_PLAY) || (state_q == S_GAP);

   beat_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_load_val),
      .en       (t_en),
      .hit      (t_hit)
   );

   always_comb begin
      // NOTE: every signal gets its default first so no branch can infer a latch.
      state_d    = state_q;
      saved_d    = saved_q;
      rom_addr_d = rom_addr_q;
      sel_d      = sel_q;
      note_d     = note_q;
      t_load     = 1'b0;
      t_load_val = '0;

      unique case (state_q)
         S_IDLE: begin
            if (play) begin
               rom_addr_d = '0;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            if (rom_note == NOTE_END) begin
               if (loop_en) begin
                  rom_addr_d = '0;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               sel_d      = rom_sel;
               note_d     = rom_note;
               t_load     = 1'b1;
               t_load_val = play_len;
               state_d    = S_PLAY;
            end
         end
         S_PLAY: begin
            if (t_hit) begin
               t_load     = 1'b1;
               t_load_val = TW'(GAP_CYC);
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            if (t_hit) begin
               // Running off the last address counts as an end marker.
               if ((rom_addr_q == '1) && !loop_en) begin
                  state_d = S_DONE;
               end else begin
                  rom_addr_d = rom_addr_q + ADDR_W'(1);
                  state_d    = S_FETCH;
               end
            end
         end
         S_PAUSE: begin
            if (play) begin
               state_d = saved_q;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The current cycle's decrement still counts; only what follows is frozen.
      if (pause && (state_q == S_PLAY || state_q == S_GAP) &&
          (state_d == S_PLAY || state_d == S_GAP)) begin
         saved_d = state_d;
         state_d = S_PAUSE;
      end

      if (stop) begin
         state_d = S_IDLE;
      end

      if (state_d == S_IDLE) begin
         rom_addr_d = '0;
         sel_d      = '0;
         note_d     = '0;
      end

      note_on_d = (state_d == S_PLAY) && (note_d != NOTE_REST);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         saved_q    <= S_PLAY;
         rom_addr_q <= '0;
         sel_q      <= '0;
         note_q     <= '0;
         note_on_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         saved_q    <= saved_d;
         rom_addr_q <= rom_addr_d;
         sel_q      <= sel_d;
         note_q     <= note_d;
         note_on_q  <= note_on_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign sel      = sel_q;
   assign note     = note_q;
   assign note_on  = note_on_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Score-playback controller that sequences `freq_controller`. It fetches note entries from a synchronous score ROM, drives the octave select and note code into `freq_controller`, and times each note's length in beats with an articulation gap. It supports play, pause, stop and loop control from the user-interface layer, and sits between the button/UI logic and the tone-generation datapath.

## Interface
Parameters:
- `ADDR_W`, 8: score ROM address width; the score holds up to 2^ADDR_W entries.
- `TICK_DIV`, 12_500_000: clk cycles per beat unit (125 ms at 100 MHz). Must be greater than `GAP_CYC`.
- `GAP_CYC`, 500_000: silent cycles at the end of every note, inside its duration.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset. Resets all state immediately.
- `play` in 1: one-cycle pulse. Starts playback from IDLE, or resumes from PAUSE.
- `pause` in 1: one-cycle pulse. Takes effect in PLAY or GAP only.
- `stop` in 1: one-cycle pulse. Returns to IDLE from any state.
- `loop_en` in 1: level. When high, playback restarts at address 0 after the end of the score.
- `rom_addr` out ADDR_W: score ROM address.
- `rom_data` in 12: ROM word, valid one cycle after `rom_addr`.
- `sel` out 2: octave select to `freq_controller`.
- `note` out 4: note code to `freq_controller`.
- `note_on` out 1: tone gate, high while a non-rest note sounds.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the score ends with `loop_en` low.

## Operation
Entry format in `rom_data`:
- [11:10] `sel`.
- [9:6] `note`: 0 is rest, 15 is end marker, 1–14 are pitches.
- [5:2] `dur`: length in beats; `dur`=0 means 16 beats.
- [1:0] reserved, ignored.

States:
- IDLE: outputs at reset values. On `play`, `rom_addr`←0, go to FETCH.
- FETCH: wait one cycle for ROM latency. Go to LOAD.
- LOAD: decode `rom_data`.
  - End marker with `loop_en`=1: `rom_addr`←0, go to FETCH.
  - End marker with `loop_en`=0: go to DONE.
  - Otherwise: register `sel` and `note`, load the timer with dur×TICK_DIV−GAP_CYC, go to PLAY.
- PLAY: `note_on` = (`note`≠0). When the timer reaches 1, load GAP_CYC and go to GAP.
- GAP: `note_on`=0; `sel` and `note` held. When the timer reaches 1, `rom_addr`←`rom_addr`+1 and go to FETCH.
  - Address wraps at 2^ADDR_W−1 → 0. A wrap is treated as an end marker: with `loop_en`=0, go to DONE instead of FETCH.
- PAUSE: timer frozen, `note_on`=0, `sel`, `note` and `rom_addr` held. On `play`, return to the saved state (PLAY or GAP) with the remaining count.
- DONE: `done`=1 for one cycle, then go to IDLE.

Control priority when pulses coincide: `stop` > `pause` > `play`. `play` while already in FETCH, LOAD, PLAY or GAP is ignored. `pause` in FETCH or LOAD is ignored.

Arithmetic: the timer width is `$clog2(16*TICK_DIV)`. The load product is computed at that width without truncation.

## Timing
Reset values: `rom_addr`=0, `sel`=0, `note`=0, `note_on`=0, `busy`=0, `done`=0, state=IDLE.

All outputs are registered.

Latency:
- `play` in cycle N: FETCH in N+1, LOAD in N+2, `note_on` first high in N+3.
- Each note occupies dur×TICK_DIV cycles across PLAY+GAP, plus 2 cycles of FETCH/LOAD overhead. Note-to-note period is dur×TICK_DIV+2.
- `stop` in cycle N: IDLE with reset-value outputs in N+1.
- `pause` in cycle N: `note_on`=0 in N+1. No timer decrement occurs in N+1.
- Resume: `play` in cycle M returns to the saved state in M+1, and decrementing resumes in M+1.

## Structure
- Shared package `music_pkg`:
  - Entry field bit positions.
  - `NOTE_REST`=0, `NOTE_END`=15.
  - `seq_state_t` enum.
  - This package is also the home of the note-code constants consumed by `freq_controller`.
- Sub-module `beat_timer`: loadable down-counter with `load`, `load_val`, `en` and `hit` (count==1) outputs. Pause drives `en` low.

## Test plan
Bench parameters: TICK_DIV=10, GAP_CYC=2.
- Play a 2-entry score {sel=1, note=5, dur=2; END} with `loop_en`=0 → `note_on` high 18 cycles then low 2 cycles, `sel`=1 and `note`=5 throughout, `done` pulses once, `busy` falls the cycle after.
- Rest entry note=0, dur=1 → `note_on` stays 0 for 10 cycles, `note`=0, sequencing continues to the next address.
- Assert `pause` 5 cycles into PLAY, hold 20 cycles, then `play` → `note_on` low during the pause, then 13 more high cycles. Total high time is unchanged at 18.
- `loop_en`=1 on a 3-entry score → `rom_addr` sequence 0,1,2,0,… with no `done` pulse. `stop` mid-note → all outputs at reset values next cycle.
- `stop`, `pause` and `play` in the same cycle → IDLE. `rst` asserted mid-GAP → outputs clear without waiting for a clock edge.
- Full ADDR_W=2 score with no end marker, `loop_en`=0 → plays addresses 0–3, then `done` pulses, with no second pass.
